// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM encoding and baud divider helper.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } uart_state_t;

   // Integer-truncated clocks per oversample tick.
   function automatic int baud_div(input int clk_freq, input int baudrate, input int oversample);
      return clk_freq / (oversample * baudrate);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable via clear.
module uart_baud_tick #(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUDRATE   = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int DIV   = uart_pkg::baud_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, single-entry holding register.
module uart_rx_8n1
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUDRATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam int TCNT_W = $clog2(OVERSAMPLE);
   localparam logic [TCNT_W-1:0] TICK_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   logic              rx_p0, rx_p1;
   uart_state_t       state, state_nxt;
   logic [TCNT_W-1:0] tick_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              tick, clear;
   logic              mid_start, bit_end, data_sample;
   logic              byte_done, stop_err;

   // Stage p0/p1: two-flop synchronizer, idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= RX;
         rx_p1 <= rx_p0;
      end
   end

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUDRATE  (BAUDRATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   assign mid_start   = tick && (tick_cnt == TICK_MID);
   assign bit_end     = tick && (tick_cnt == TICK_LAST);
   assign data_sample = (state == ST_DATA) && bit_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      byte_done = 1'b0;
      stop_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_p1) begin
               state_nxt = ST_START;
               clear     = 1'b1;
            end
         end
         ST_START: begin
            if (mid_start) begin
               state_nxt = rx_p1 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end && (bit_idx == BIT_LAST)) begin
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (rx_p1) begin
                  byte_done = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stop_err  = 1'b1;
                  state_nxt = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_p1) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Tick count realigns to mid-bit after the start check; later bits wrap every 16 ticks
   always_ff @(posedge clk) begin
      if (rst || (state == ST_IDLE)) begin
         tick_cnt <= '0;
      end else if (tick) begin
         if ((state == ST_START) && (tick_cnt == TICK_MID)) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (state == ST_IDLE)) begin
         bit_idx <= '0;
      end else if (data_sample) begin
         bit_idx <= bit_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
      end else if (data_sample) begin
         shreg <= {rx_p1, shreg[7:1]};
      end
   end

   // Holding register: a simultaneous accept lets a new byte replace the old one
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= stop_err;
         rx_overrun   <= byte_done && rx_valid && !rx_ready;
         if (byte_done && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = (state != ST_IDLE);

endmodule
